gray_codec_pipe: RTL

- Parametrised, pipelined bidirectional Gray/binary converter with a valid/ready handshake on both sides.
- Per-transaction mode selects Gray->binary or binary->Gray.
- Successor to the fixed 4-bit combinational Gray decoder. Used where Gray-coded counter values (e.g. async-FIFO pointers, encoder positions) cross into registered datapaths that may apply backpressure.

---
 rtl/gray_codec_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage pipelined Gray<->binary converter with a
// valid/ready handshake on both sides. The mode bit travels with each word.
// Optional Gray step checker enabled by defining GRAY_STEP_CHK_EN, which adds
// the step_err output: set when consecutive Gray->binary inputs do not differ
// in exactly one bit.
module gray_codec_pipe #(
    parameter int WIDTH = 8,
    parameter int SPLIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
`ifdef GRAY_STEP_CHK_EN
    ,
    output logic             step_err
`endif
);

    localparam int unsigned W      = WIDTH;
    localparam int unsigned HI     = (W + 1) / 2;
    // Prefix-chain bits [1, S1_END) are resolved in S1, the rest in S2.
    localparam int unsigned S1_END = (SPLIT != 0) ? HI : 1;

    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s2_valid;
    logic             r_s2_mode;
    logic [WIDTH-1:0] r_s2_data;

    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_s1_next;
    logic [WIDTH-1:0] w_s2_next;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && w_s1_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_s2_valid;
    assign out_mode  = r_s2_mode;
    assign out_data  = r_s2_data;

    // Stage-1 conversion: upper part of the Gray prefix chain (SPLIT=1 only).
    always_comb begin
        logic [WIDTH-1:0] v;
        v = in_data;
        if (!in_mode) begin
            for (int unsigned k = 1; k < S1_END; k++) begin
                v[W-1-k] = v[W-k] ^ v[W-1-k];
            end
        end
        w_s1_next = v;
    end

    // Stage-2 conversion: finish the prefix chain, or binary->Gray encode.
    always_comb begin
        logic [WIDTH-1:0] v;
        v = r_s1_data;
        if (r_s1_mode) begin
            v = r_s1_data ^ (r_s1_data >> 1);
        end else begin
            // Bit W-S1_END is already final, so the chain continues from it.
            for (int unsigned k = S1_END; k < W; k++) begin
                v[W-1-k] = v[W-k] ^ v[W-1-k];
            end
        end
        w_s2_next = v;
    end

    // Stage-1 register: accepts a new word whenever it can hand its own on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= in_mode;
                r_s1_data <= w_s1_next;
            end
        end
    end

    // Stage-2 register: output stage, holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode <= r_s1_mode;
                r_s2_data <= w_s2_next;
            end
        end
    end

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0] r_last;
    logic             r_have_last;
    logic             r_s1_err;
    logic             r_s2_err;
    logic             w_step_bad;

    assign w_step_bad = !in_mode && r_have_last && ($countones(in_data ^ r_last) != 1);
    assign step_err   = r_s2_err;

    // Track the previous Gray->binary input word; binary->Gray words are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_have_last <= 1'b0;
        end else if (w_in_xfer && !in_mode) begin
            r_last      <= in_data;
            r_have_last <= 1'b1;
        end
    end

    // Error sideband pipelined alongside the data words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_err <= 1'b0;
            r_s2_err <= 1'b0;
        end else begin
            if (w_s1_load && in_valid) begin
                r_s1_err <= w_step_bad;
            end
            if (w_s2_load && r_s1_valid) begin
                r_s2_err <= r_s1_err;
            end
        end
    end
`endif

endmodule
